cla4_adder: RTL and testbench

//  4-bit carry-lookahead adder slice with registered outputs, single clock domain.

---
 rtl/cla4_adder.sv | 112 +++++++++++
 tb/tb_cla4_adder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cla4_adder.sv
// 4-bit carry-lookahead adder slice with registered sum, carry-out and group P/G outputs.
// Build option: define CLA_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module cla4_adder (
   input  logic clk,
   input  logic rst,
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic a3,
   input  logic b0,
   input  logic b1,
   input  logic b2,
   input  logic b3,
   input  logic c0,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic c4,
   output logic p4,
   output logic g4_inv
);

   logic [3:0] a_s;
   logic [3:0] b_s;
   logic       cin_s;
   logic [3:0] g_s;
   logic [3:0] p_s;
   logic [4:1] c_s;
   logic [3:0] sum_s;
   logic       grp_p_s;
   logic       grp_g_s;

`ifdef CLA_IN_REG_EN
   logic [3:0] a_r;
   logic [3:0] b_r;
   logic       cin_r;

   // Input capture stage; cleared by reset so the stage behind it sees zero operands
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= 4'b0000;
         b_r   <= 4'b0000;
         cin_r <= 1'b0;
      end else begin
         a_r   <= {a3, a2, a1, a0};
         b_r   <= {b3, b2, b1, b0};
         cin_r <= c0;
      end
   end

   assign a_s   = a_r;
   assign b_s   = b_r;
   assign cin_s = cin_r;
`else
   assign a_s   = {a3, a2, a1, a0};
   assign b_s   = {b3, b2, b1, b0};
   assign cin_s = c0;
`endif

   // Per-bit generate/propagate and two-level sum-of-products carries (no ripple path)
   always_comb begin
      g_s = a_s & b_s;
      p_s = a_s ^ b_s;

      c_s[1] = g_s[0]
             | (p_s[0] & cin_s);
      c_s[2] = g_s[1]
             | (p_s[1] & g_s[0])
             | (p_s[1] & p_s[0] & cin_s);
      c_s[3] = g_s[2]
             | (p_s[2] & g_s[1])
             | (p_s[2] & p_s[1] & g_s[0])
             | (p_s[2] & p_s[1] & p_s[0] & cin_s);
      c_s[4] = g_s[3]
             | (p_s[3] & g_s[2])
             | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin_s);

      // Group terms exclude carry-in so a second-level lookahead can combine slices
      grp_p_s = p_s[3] & p_s[2] & p_s[1] & p_s[0];
      grp_g_s = g_s[3]
              | (p_s[3] & g_s[2])
              | (p_s[3] & p_s[2] & g_s[1])
              | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);

      sum_s = p_s ^ {c_s[3], c_s[2], c_s[1], cin_s};
   end

   // Output register stage; reset value equals the all-zero-operand result
   always_ff @(posedge clk) begin
      if (rst) begin
         s0     <= 1'b0;
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         c4     <= 1'b0;
         p4     <= 1'b0;
         g4_inv <= 1'b1;
      end else begin
         s0     <= sum_s[0];
         s1     <= sum_s[1];
         s2     <= sum_s[2];
         s3     <= sum_s[3];
         c4     <= c_s[4];
         p4     <= grp_p_s;
         g4_inv <= ~grp_g_s;
      end
   end

endmodule

// File: tb/tb_cla4_adder.sv
// Scoreboard bench for cla4_adder: driver queues expected results, a monitor checks each cycle.
// Honors CLA_IN_REG_EN the same way the design does (latency 2 when defined).
`timescale 1ns/1ps
module tb_cla4_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
   logic b0 = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
   logic c0 = 1'b0;
   logic s0, s1, s2, s3, c4, p4, g4_inv;

   always #5 clk = ~clk;

   cla4_adder dut (
      .clk(clk), .rst(rst),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3),
      .b0(b0), .b1(b1), .b2(b2), .b3(b3),
      .c0(c0),
      .s0(s0), .s1(s1), .s2(s2), .s3(s3),
      .c4(c4), .p4(p4), .g4_inv(g4_inv)
   );

   // expected vector layout: {c4, s[3:0], p4, g4_inv}
   logic [6:0] exp_q[$];
   string      name_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [8:0] prev_eff = 9'd0;  // {c0, b, a} held in the input stage (latency-2 build)

   // Reference: plain arithmetic on the operand values.
   function automatic logic [6:0] ref_out(input logic [3:0] a, input logic [3:0] b, input logic c);
      int sum_ab;
      int sum_all;
      logic [4:0] sv;
      logic grp_p;
      logic grp_g;
      sum_ab  = int'(a) + int'(b);
      sum_all = sum_ab + int'(c);
      sv      = 5'(sum_all);
      grp_p   = ((a ^ b) == 4'hF);     // every bit position propagates
      grp_g   = (sum_ab > 15);         // slice produces a carry with zero carry-in
      return {sv, grp_p, ~grp_g};
   endfunction

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic r, input string nm);
      logic [6:0] e;
      logic [8:0] cur;
      @(negedge clk);
      {a3, a2, a1, a0} = a;
      {b3, b2, b1, b0} = b;
      c0  = c;
      rst = r;
      cur = {c, b, a};
`ifdef CLA_IN_REG_EN
      e = r ? ref_out(4'd0, 4'd0, 1'b0) : ref_out(prev_eff[3:0], prev_eff[7:4], prev_eff[8]);
`else
      e = r ? ref_out(4'd0, 4'd0, 1'b0) : ref_out(cur[3:0], cur[7:4], cur[8]);
`endif
      prev_eff = r ? 9'd0 : cur;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: one result per clock, checked shortly after the capturing edge
   initial begin
      logic [6:0] e;
      logic [6:0] got;
      string      nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {c4, s3, s2, s1, s0, p4, g4_inv};
            n_cmp++;
            if (got !== e) begin
               n_err++;
               $display("FAIL %s: got c4,s,p4,g4_inv=%b,%b,%b,%b required %b,%b,%b,%b",
                        nm, got[6], got[5:2], got[1], got[0], e[6], e[5:2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      logic [8:0] v;
      logic       r;
      // reset with all-ones operands on the inputs
      drive(4'hF, 4'hF, 1'b1, 1'b1, "reset1");
      drive(4'hF, 4'hF, 1'b1, 1'b1, "reset2");
      // directed cases
      drive(4'b0000, 4'b0001, 1'b0, 1'b0, "a0_b1");
      drive(4'b1111, 4'b0001, 1'b0, 1'b0, "wrap_gen");
      drive(4'b1010, 4'b0111, 1'b1, 1'b0, "a10_b7_c1");
      drive(4'b0101, 4'b1010, 1'b0, 1'b0, "prop_c0");
      drive(4'b0101, 4'b1010, 1'b1, 1'b0, "prop_c1");
      drive(4'b1111, 4'b1111, 1'b1, 1'b0, "max");
      // exhaustive back-to-back sweep with a reset pulse in the middle
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         r = (i == 200);
         drive(v[8:5], v[4:1], v[0], r, r ? "sweep_rst" : "sweep");
      end
      // randomized stream with occasional resets
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 31) == 0);
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), r, r ? "rand_rst" : "rand");
      end
      // drain the scoreboard with a bounded wait
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending results required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
